frame_header_tx: RTL and testbench

FRAME_HEADER_TX -- requirements
Module: frame_header_tx

---
 rtl/frame_header_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_frame_header_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_header_tx.sv
// ---------------------------------------------------------------------------
// frame_header_tx
//
// Prepends a fixed Ethernet-style header (destination MAC, source MAC,
// ethertype) to a dibit payload stream and enforces an inter-frame gap.
// The payload is buffered in a 64-entry dibit FIFO while the 56 header
// dibits go out, which gives a fixed 57-cycle input-to-output latency.
//
// Parameters
//   DST_MAC  destination address sent in every frame
//   SRC_MAC  source address (this station) sent in every frame
//   ETYPE    ethertype sent in every frame
//   IFG      idle cycles (axiov low) after every frame, must be >= 1
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst      asynchronous reset, active low
//   axiiv    payload dibit valid, high for the whole payload
//   axiid    payload dibit
//   axiov    output dibit valid (registered)
//   axiod    output dibit, header then payload, 2'b00 when not valid
//   busy     high whenever the block is not idle (registered)
//   drop     one-cycle pulse when an input frame or dibit is discarded
// ---------------------------------------------------------------------------
module frame_header_tx #(
    parameter logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC = 48'h69_69_5A_06_54_91,
    parameter logic [15:0] ETYPE   = 16'h0800,
    parameter int          IFG     = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       drop
);

    localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(IFG - 1);
    localparam logic [5:0] HDR_LAST = 6'd55;
    localparam logic [6:0] FIFO_DEPTH = 7'd64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [5:0]      hcnt_q, hcnt_d;      // header dibit currently on axiod
    logic [GW-1:0]   gcnt_q, gcnt_d;      // cycles spent in GAP
    logic            open_q, open_d;      // frame still accepting payload
    logic            armed_q, armed_d;    // axiiv was low last cycle
    logic [5:0]      wptr_q, wptr_d;
    logic [5:0]      rptr_q, rptr_d;
    logic [6:0]      cnt_q, cnt_d;        // FIFO occupancy 0..64
    logic            axiov_q, axiov_d;
    logic [1:0]      axiod_q, axiod_d;
    logic            busy_q, busy_d;
    logic            drop_q, drop_d;

    logic [1:0]      mem_q [64];

    // -----------------------------------------------------------------------
    // Header lookup: dibit k lives at bits [111-2k -: 2] of the header.
    // -----------------------------------------------------------------------
    logic [111:0] hdr_bits;
    logic [5:0]   hdr_idx;
    logic [1:0]   hdr_dibit;

    assign hdr_bits  = {DST_MAC, SRC_MAC, ETYPE};
    // Index of the header dibit to present next cycle. Clamped on the last
    // header dibit so the part-select never leaves the vector.
    assign hdr_idx   = (state_q == HDR && hcnt_q != HDR_LAST) ? hcnt_q + 6'd1 : 6'd0;
    assign hdr_dibit = hdr_bits[7'd111 - {hdr_idx, 1'b0} -: 2];

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    logic start;
    logic discard;
    logic wr_req;
    logic wr_en;
    logic rd_en;
    logic fifo_empty;
    logic fifo_full;
    logic [1:0] fifo_head;

    assign fifo_empty = (cnt_q == 7'd0);
    assign fifo_full  = (cnt_q == FIFO_DEPTH);
    assign fifo_head  = mem_q[rptr_q];

    // A frame starts only on a rising axiiv seen in IDLE; armed_q keeps a
    // stream that was already running (e.g. across reset release or across
    // a discarded frame) from being framed part-way through.
    assign start   = (state_q == IDLE) && axiiv && armed_q;

    // A rising axiiv while busy with a closed frame is a new frame that
    // cannot be served; it is flagged once and its dibits are ignored.
    assign discard = (state_q != IDLE) && !open_q && axiiv && armed_q;

    assign wr_req  = start ||
                     (open_q && axiiv && (state_q == HDR || state_q == PAY));
    assign wr_en   = wr_req && !fifo_full;

    // The pop on the last header dibit lands payload dibit 0 in cycle 57.
    assign rd_en   = !fifo_empty &&
                     ((state_q == HDR && hcnt_q == HDR_LAST) || state_q == PAY);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= axiid;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        open_d  = open_q;
        axiov_d = 1'b0;
        axiod_d = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR;
                    hcnt_d  = 6'd0;
                    axiov_d = 1'b1;
                    axiod_d = hdr_dibit;
                end
            end

            HDR: begin
                if (hcnt_q == HDR_LAST) begin
                    state_d = PAY;
                    if (!fifo_empty) begin
                        axiov_d = 1'b1;
                        axiod_d = fifo_head;
                    end
                end else begin
                    hcnt_d  = hcnt_q + 6'd1;
                    axiov_d = 1'b1;
                    axiod_d = hdr_dibit;
                end
            end

            PAY: begin
                if (!fifo_empty) begin
                    axiov_d = 1'b1;
                    axiod_d = fifo_head;
                end else if (!open_q) begin
                    state_d = GAP;
                    gcnt_d  = '0;
                end
                // Empty with the frame still open cannot occur for a
                // contiguous payload; the output simply idles if it does.
            end

            GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // The first low axiiv after the start closes the frame for good.
        if (start) begin
            open_d = 1'b1;
        end else if (open_q && !axiiv) begin
            open_d = 1'b0;
        end
    end

    assign armed_d = !axiiv;
    assign wptr_d  = wptr_q + {5'd0, wr_en};
    assign rptr_d  = rptr_q + {5'd0, rd_en};
    assign cnt_d   = cnt_q + {6'd0, wr_en} - {6'd0, rd_en};
    assign busy_d  = (state_d != IDLE);
    assign drop_d  = discard || (wr_req && fifo_full);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hcnt_q  <= 6'd0;
            gcnt_q  <= '0;
            open_q  <= 1'b0;
            armed_q <= 1'b0;
            wptr_q  <= 6'd0;
            rptr_q  <= 6'd0;
            cnt_q   <= 7'd0;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            gcnt_q  <= gcnt_d;
            open_q  <= open_d;
            armed_q <= armed_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;
    assign busy  = busy_q;
    assign drop  = drop_q;

endmodule

// File: tb/tb_frame_header_tx.sv
// Bench for frame_header_tx. Two instances share one stimulus stream:
// dut 0 uses default parameters, dut 1 uses DST_MAC = SRC_MAC and a short
// IFG. Expected outputs come from a frame-level model: every accepted frame
// yields 56 header dibits then its payload starting one cycle after the
// start, followed by IFG gap cycles; a rising axiiv before the block is
// free again is dropped.
module tb_frame_header_tx;
    localparam logic [47:0] SRC  = 48'h69_69_5A_06_54_91;
    localparam logic [47:0] DST0 = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] DST1 = 48'h69_69_5A_06_54_91;
    localparam int IFG0 = 48;
    localparam int IFG1 = 5;
    localparam int MAXT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic axiiv = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic [1:0] ov;
    logic [1:0] od0, od1;
    logic [1:0] bz;
    logic [1:0] dr;

    frame_header_tx u_dut0 (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(ov[0]), .axiod(od0), .busy(bz[0]), .drop(dr[0])
    );

    frame_header_tx #(.DST_MAC(DST1), .IFG(IFG1)) u_dut1 (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(ov[1]), .axiod(od1), .busy(bz[1]), .drop(dr[1])
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus and per-cycle words {axiov, axiod[1:0], busy, drop}
    bit         in_v [MAXT];
    logic [1:0] in_d [MAXT];
    logic [4:0] obs_w [2][MAXT];
    logic [4:0] exp_w [2][MAXT];
    int         n_cyc;

    function automatic logic [1:0] hdr_dibit(input logic [47:0] dst, input int k);
        logic [111:0] h;
        h = {dst, SRC, 16'h0800};
        return 2'(h >> (110 - 2 * k));
    endfunction

    task automatic build_model(input int u, input logic [47:0] dst, input int ifg);
        int t_free;
        int len;
        t_free = 0;
        for (int t = 0; t < n_cyc; t++) exp_w[u][t] = 5'd0;
        for (int t = 1; t < n_cyc; t++) begin
            if (in_v[t] && !in_v[t-1]) begin
                if (t >= t_free) begin
                    len = 0;
                    while (t + len < n_cyc && in_v[t+len]) len++;
                    for (int k = 0; k < 56; k++)
                        if (t + 1 + k < n_cyc)
                            exp_w[u][t+1+k] = exp_w[u][t+1+k] | {1'b1, hdr_dibit(dst, k), 2'b00};
                    for (int i = 0; i < len; i++)
                        if (t + 57 + i < n_cyc)
                            exp_w[u][t+57+i] = exp_w[u][t+57+i] | {1'b1, in_d[t+i], 2'b00};
                    for (int c = t + 1; c <= t + 56 + len + ifg; c++)
                        if (c < n_cyc) exp_w[u][c] = exp_w[u][c] | 5'b00010;
                    t_free = t + 57 + len + ifg;
                end else if (t + 1 < n_cyc) begin
                    exp_w[u][t+1] = exp_w[u][t+1] | 5'b00001;
                end
            end
        end
    endtask

    task automatic clear_stim(input int n);
        for (int t = 0; t < n; t++) begin
            in_v[t] = 1'b0;
            in_d[t] = 2'b00;
        end
    endtask

    // dval < 0 gives random payload dibits
    task automatic put_frame(input int s, input int len, input int dval);
        for (int i = 0; i < len; i++) begin
            in_v[s+i] = 1'b1;
            in_d[s+i] = (dval < 0) ? 2'($urandom_range(0, 3)) : 2'(dval);
        end
    endtask

    // Resets both DUTs, plays the stimulus and compares every cycle against
    // the model. abort_at >= 0 asserts reset mid-cycle at that cycle.
    task automatic run_trace(input string name, input int n, input int abort_at);
        int lim;
        n_cyc = n;
        build_model(0, DST0, IFG0);
        build_model(1, DST1, IFG1);
        @(negedge clk);
        rst = 1'b0;
        axiiv = in_v[0];
        axiid = 2'b00;
        #1;
        chk({name, " reset d0"}, {ov[0], od0, bz[0], dr[0]}, 5'd0);
        chk({name, " reset d1"}, {ov[1], od1, bz[1], dr[1]}, 5'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lim = n;
        for (int t = 0; t < n; t++) begin
            if (t == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                chk({name, " abort d0"}, {ov[0], od0, bz[0], dr[0]}, 5'd0);
                chk({name, " abort d1"}, {ov[1], od1, bz[1], dr[1]}, 5'd0);
                lim = t;
                break;
            end
            obs_w[0][t] = {ov[0], od0, bz[0], dr[0]};
            obs_w[1][t] = {ov[1], od1, bz[1], dr[1]};
            axiiv = in_v[t];
            axiid = in_d[t];
            @(negedge clk);
        end
        axiiv = 1'b0;
        for (int t = 0; t < lim; t++)
            for (int u = 0; u < 2; u++)
                chk($sformatf("%s d%0d cyc%0d", name, u, t), obs_w[u][t], exp_w[u][t]);
    endtask

    function automatic int count_bit(input int u, input int b, input int from, input int to);
        int c;
        c = 0;
        for (int t = from; t <= to; t++) if (obs_w[u][t][b]) c++;
        return c;
    endfunction

    initial begin
        int s;
        int et [8];
        int sm [4];
        int gapc;
        et = '{0, 0, 2, 0, 0, 0, 0, 0};
        sm = '{1, 2, 2, 1};

        // 20 payload dibits of 01, default parameters
        s = 3;
        clear_stim(200);
        put_frame(s, 20, 1);
        run_trace("t1", 200, -1);
        chk("t1 dst first", obs_w[0][s+1], 5'b1_11_1_0);
        chk("t1 dst last", obs_w[0][s+24], 5'b1_11_1_0);
        for (int i = 0; i < 4; i++) chk($sformatf("t1 src%0d", i), obs_w[0][s+25+i][3:2], sm[i]);
        for (int i = 0; i < 8; i++) chk($sformatf("t1 etype%0d", i), obs_w[0][s+49+i][3:2], et[i]);
        chk("t1 pay first", obs_w[0][s+57], 5'b1_01_1_0);
        chk("t1 pay last", obs_w[0][s+76], 5'b1_01_1_0);
        chk("t1 gap start", obs_w[0][s+77], 5'b0_00_1_0);
        chk("t1 busy end", obs_w[0][s+124][1], 1);
        chk("t1 idle", obs_w[0][s+125][1], 0);

        // 1-dibit payload, DST = SRC on dut 1
        clear_stim(120);
        put_frame(s, 1, 2);
        run_trace("t2", 120, -1);
        for (int i = 0; i < 4; i++) chk($sformatf("t2 dst%0d", i), obs_w[1][s+1+i][3:2], sm[i]);
        chk("t2 pay", obs_w[1][s+57], 5'b1_10_1_0);
        chk("t2 end", obs_w[1][s+58][4], 0);
        chk("t2 valid count", count_bit(0, 4, 0, 119), 57);

        // second frame 10 cycles after the first one closes
        clear_stim(250);
        put_frame(s, 20, -1);
        put_frame(s + 30, 15, -1);
        run_trace("t3", 250, -1);
        chk("t3 drop pulse", obs_w[0][s+31][0], 1);
        chk("t3 drop count d0", count_bit(0, 0, 0, 249), 1);
        chk("t3 drop count d1", count_bit(1, 0, 0, 249), 1);
        chk("t3 valid d0", count_bit(0, 4, 0, 249), 76);
        chk("t3 valid d1", count_bit(1, 4, 0, 249), 76);

        // reset mid-frame, then a stream already running at release
        clear_stim(100);
        put_frame(s, 40, -1);
        run_trace("t4", 100, s + 30);
        clear_stim(150);
        put_frame(0, 10, -1);
        put_frame(20, 5, -1);
        run_trace("t5", 150, -1);
        chk("t5 no stale frame", count_bit(0, 4, 0, 20), 0);
        chk("t5 hdr start", obs_w[0][21], 5'b1_11_1_0);

        // second frame in the first IDLE cycle
        clear_stim(300);
        put_frame(s, 20, -1);
        put_frame(s + 125, 10, -1);
        run_trace("t6", 300, -1);
        gapc = 0;
        for (int t = s + 77; t <= s + 125; t++)
            if (!obs_w[0][t][4] && obs_w[0][t][1]) gapc++;
        chk("t6 gap cycles", gapc, IFG0);
        chk("t6 idle cycle", obs_w[0][s+125][1], 0);
        chk("t6 second hdr", obs_w[0][s+126], 5'b1_11_1_0);
        chk("t6 no drop", count_bit(0, 0, 0, 299), 0);

        // random traffic
        for (int r = 0; r < 3; r++) begin
            int t;
            int len;
            clear_stim(1500);
            t = 2;
            while (t < 1200) begin
                t += $urandom_range(1, 130);
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 80) : $urandom_range(1, 30);
                put_frame(t, len, -1);
                t += len;
            end
            run_trace($sformatf("rnd%0d", r), 1500, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
